parking_occupancy_ctrl: RTL and testbench
=========================================

# parking_occupancy_ctrl

Occupancy controller for the smart parking system. Sits directly upstream of the 8-bit `adderSubtractor`: it arbitrates entry/exit sensor requests and drives the adder's operands and `sel`. It then registers the adder's sum as the live occupancy count and sequences the entry/exit gates.

## Interface
Parameters:
- `CAPACITY`, 8'd200: number of bays; `full` asserts at `count >= CAPACITY`; legal range 1..255.
- `GATE_CYCLES`, 4: number of cycles a gate is held open after a grant; legal range 1..255.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `entry_req`, input, 1: car at entry sensor; a level signal, already synchronised.
- `exit_req`, input, 1: car at exit sensor; a level signal, already synchronised.
- `entry_grant`, output, 1: one-cycle pulse when an entry is committed.
- `exit_grant`, output, 1: one-cycle pulse when an exit is committed.
- `gate_in_open`, output, 1: entry gate drive.
- `gate_out_open`, output, 1: exit gate drive.
- `count`, output, 8: registered occupancy.
- `full`, output, 1: `count >= CAPACITY`, combinational from `count`.
- `empty`, output, 1: `count == 0`, combinational from `count`.
- `err`, output, 1: sticky arithmetic fault; cleared only by `rst`.

## Operation
- The state machine has five states: IDLE, CALC, COMMIT, GATE and RELEASE.
- A request is eligible under these rules:
  - An entry is eligible when `entry_req && !full`.
  - An exit is eligible when `exit_req && !empty`.
  - Ineligible requests are ignored; no grant is issued and no error is raised.
- IDLE behaviour:
  - If only one request is eligible, latch its direction (`dir`: 0 = entry/add, 1 = exit/sub) and go to CALC.
  - If both are eligible, serve the direction opposite to `last_dir`.
  - `last_dir` resets to exit, so entry wins the first tie.
- CALC: drive the adder with `A = count`, `B = 8'd1`, `sel = dir`. This state exists only to give the combinational ripple a full cycle.
- COMMIT:
  - Load `S` into `count`.
  - Pulse the grant matching `dir`.
  - Update `last_dir <= dir`.
  - Arithmetic check on the adder's `cout`:
    - On an add, `cout = 1` means overflow.
    - On a sub, `cout = 0` means borrow.
    - If either occurs: do not load `count`, suppress the grant, set `err`, and return to IDLE.
- GATE: assert the gate matching `dir` for exactly `GATE_CYCLES` cycles, using an 8-bit down-counter, then go to RELEASE.
- RELEASE: gate closed; wait until the served request is low, then go to IDLE. This prevents double-counting a car that lingers on the sensor. The opposite request is not examined here.
- Width rule: all arithmetic is 8-bit unsigned, performed through the adder; there is no other adder or subtractor in the block.

## Timing
- Reset values: `count` = 0, `empty` = 1, `full` = 0, all grants and gates 0, `err` = 0, state IDLE, `last_dir` = 1.
- Latency from a request sampled in IDLE at edge 0:
  - CALC runs in cycle 1.
  - COMMIT runs in cycle 2, with the grant high during that cycle.
  - The new `count` is visible from edge 3.
  - The gate is open for cycles 3 .. 2+`GATE_CYCLES`.
- Minimum service interval: 3 + `GATE_CYCLES` + 1 cycles per car.
- A request that arrives while the block is not in IDLE is held by the sensor level and is serviced later; none are lost.
- Reset mid-operation:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - An open gate closes.
  - An in-flight count update is discarded.
- Eligibility for `full`/`empty` is evaluated in IDLE only; a count change never occurs outside COMMIT.

## Structure
- Shared package `parking_pkg` holds:
  - the state enum;
  - `OP_ADD = 1'b0` and `OP_SUB = 1'b1`, matching the adder's `sel`;
  - the default values for `CAPACITY` and `GATE_CYCLES`.
- One sub-module: a single instance of the existing `adderSubtractor`, with its `A`, `B`, `sel`, `S` and `cout` ports wired as described above.

## Test plan
- Reset: assert `rst` asynchronously → `count` = 0, `empty` = 1, `full` = 0, `err` = 0, both gates 0.
- Single entry (`GATE_CYCLES` = 4): `entry_req` high from cycle 0 → `entry_grant` high in cycle 2, `count` = 1 from edge 3, `gate_in_open` high in cycles 3–6. Hold the request through cycle 9 → no second grant; drop it → back to IDLE.
- Simultaneous requests with `count` = 5 and both requests held high:
  - first the entry is granted and `count` becomes 6;
  - then, after its request drops, the exit is granted and `count` becomes 5.
- Capacity (`CAPACITY` = 3): three entries give `count` = 3 and `full` = 1. A fourth `entry_req` produces no grant and `count` stays 3. An exit is then granted: `count` = 2, `full` = 0.
- Exit at empty: `exit_req` with `count` = 0 → no grant, `count` stays 0, `err` stays 0.
- Reset mid-gate: assert `rst` during GATE cycle 4 → `gate_in_open` falls without a clock edge and `count` = 0. Release `rst` → the block is in IDLE and accepts a new entry.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the smart parking occupancy controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    COMMIT,
    GATE,
    RELEASE
  } state_t;

  // Operation select values, matching the adderSubtractor sel input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [7:0] DEF_CAPACITY    = 8'd200;
  localparam logic [7:0] DEF_GATE_CYCLES = 8'd4;

endpackage

// File: rtl/adderSubtractor.sv
// 8-bit ripple-carry adder/subtractor: S = A + B (sel=0) or A - B (sel=1).
// On a subtract, cout=1 means no borrow occurred.
module adderSubtractor (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       sel,
  output logic [7:0] S,
  output logic       cout
);

  logic [7:0] bEff;
  logic [8:0] carry;

  always_comb begin
    bEff     = B ^ {8{sel}};
    carry    = 9'b0;
    carry[0] = sel;
    S        = 8'b0;
    for (int i = 0; i < 8; i++) begin
      S[i]       = A[i] ^ bEff[i] ^ carry[i];
      carry[i+1] = (A[i] & bEff[i]) | (carry[i] & (A[i] ^ bEff[i]));
    end
  end

  assign cout = carry[8];

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy controller: arbitrates entry/exit sensors, updates the live count
// through the shared adderSubtractor and sequences the entry/exit gates.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter logic [7:0] CAPACITY    = DEF_CAPACITY,
  parameter logic [7:0] GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic       entry_grant,
  output logic       exit_grant,
  output logic       gate_in_open,
  output logic       gate_out_open,
  output logic [7:0] count,
  output logic       full,
  output logic       empty,
  output logic       err
);

  state_t     state, state_next;
  logic       dir, dir_next, last_dir;
  logic [7:0] gate_cnt;
  logic [7:0] add_a, add_s;
  logic       add_sel, add_cout;
  logic       entry_ok, exit_ok, fault, commit_ok;

  assign full     = (count >= CAPACITY);
  assign empty    = (count == 8'd0);
  assign entry_ok = entry_req && !full;
  assign exit_ok  = exit_req && !empty;

  // The adder is idle while a gate is open, so it also decrements the gate timer.
  assign add_a     = (state == GATE) ? gate_cnt : count;
  assign add_sel   = (state == GATE) ? OP_SUB : dir;
  assign fault     = (dir == OP_ADD) ? add_cout : !add_cout;
  assign commit_ok = (state == COMMIT) && !fault;

  adderSubtractor u_adder (
    .A    (add_a),
    .B    (8'd1),
    .sel  (add_sel),
    .S    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    dir_next      = dir;
    entry_grant   = 1'b0;
    exit_grant    = 1'b0;
    gate_in_open  = 1'b0;
    gate_out_open = 1'b0;
    case (state)
      IDLE: begin
        if (entry_ok && exit_ok) begin
          dir_next   = !last_dir;
          state_next = CALC;
        end else if (entry_ok) begin
          dir_next   = OP_ADD;
          state_next = CALC;
        end else if (exit_ok) begin
          dir_next   = OP_SUB;
          state_next = CALC;
        end
      end
      CALC: state_next = COMMIT;
      COMMIT: begin
        entry_grant = commit_ok && (dir == OP_ADD);
        exit_grant  = commit_ok && (dir == OP_SUB);
        state_next  = fault ? IDLE : GATE;
      end
      GATE: begin
        gate_in_open  = (dir == OP_ADD);
        gate_out_open = (dir == OP_SUB);
        if (gate_cnt == 8'd1) state_next = RELEASE;
      end
      // Hold here until the served car clears its sensor so it is counted once.
      RELEASE: begin
        if ((dir == OP_ADD) ? !entry_req : !exit_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 8'd0;
      dir      <= OP_ADD;
      last_dir <= OP_SUB;
      err      <= 1'b0;
      gate_cnt <= 8'd0;
    end else begin
      dir <= dir_next;
      if (commit_ok) begin
        count    <= add_s;
        last_dir <= dir;
        gate_cnt <= GATE_CYCLES;
      end else if (state == GATE) begin
        gate_cnt <= add_s;
      end
      if ((state == COMMIT) && fault) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl: stimulus queues expected grants,
// a monitor checks each grant, the resulting count and the gate window.
module tb_parking_occupancy_ctrl;

  localparam logic [7:0] CAP = 8'd6;
  localparam logic [7:0] GC  = 8'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       entry_grant, exit_grant, gate_in_open, gate_out_open;
  logic       full, empty, err;
  logic [7:0] count;

  typedef struct {
    bit isExit;
    int countAfter;
    int grantCycle;
    int gateChecks;
    bit closeCheck;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   busy = 1'b0;

  parking_occupancy_ctrl #(
    .CAPACITY    (CAP),
    .GATE_CYCLES (GC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .entry_grant   (entry_grant),
    .exit_grant    (exit_grant),
    .gate_in_open  (gate_in_open),
    .gate_out_open (gate_out_open),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ent, input logic ex);
    @(negedge clk);
    entry_req = ent;
    exit_req  = ex;
  endtask

  task automatic expectCar(input bit isExit, input int countAfter, input int grantCycle,
                           input int gateChecks, input bit closeCheck);
    exp_t e;
    e.isExit     = isExit;
    e.countAfter = countAfter;
    e.grantCycle = grantCycle;
    e.gateChecks = gateChecks;
    e.closeCheck = closeCheck;
    sb.push_back(e);
  endtask

  task automatic waitQueue(input int left, input int maxCycles, input string name);
    int n = 0;
    while ((sb.size() > left || busy) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, (sb.size() > left || busy) ? 1 : 0, 0);
  endtask

  task automatic serveCar(input bit isExit, input int countAfter);
    expectCar(isExit, countAfter, -1, GC, 1'b1);
    applyStimulus(!isExit, isExit);
    waitQueue(0, 30, isExit ? "serve_exit" : "serve_entry");
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic holdNoGrant(input logic ent, input logic ex, input int cycles);
    applyStimulus(ent, ex);
    repeat (cycles) @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every grant must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (entry_grant || exit_grant) begin
        busy = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_grant", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("grant_entry", entry_grant, !e.isExit);
          checkOutput("grant_exit", exit_grant, e.isExit);
          if (e.grantCycle >= 0) checkOutput("grant_cycle", cyc, e.grantCycle);
          for (int i = 0; i < e.gateChecks; i++) begin
            @(negedge clk);
            if (i == 0) begin
              checkOutput("count_after", count, e.countAfter);
              checkOutput("full_after", full, (e.countAfter >= CAP) ? 1 : 0);
              checkOutput("empty_after", empty, (e.countAfter == 0) ? 1 : 0);
            end
            checkOutput("gate_in_window", gate_in_open, !e.isExit);
            checkOutput("gate_out_window", gate_out_open, e.isExit);
          end
          if (e.closeCheck) begin
            @(negedge clk);
            checkOutput("gate_in_closed", gate_in_open, 0);
            checkOutput("gate_out_closed", gate_out_open, 0);
          end
        end
        busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_count", count, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_gate_in", gate_in_open, 0);
    checkOutput("reset_gate_out", gate_out_open, 0);
    checkOutput("reset_grants", {entry_grant, exit_grant}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single entry held long after service: exactly one grant, at cycle +2.
    @(negedge clk);
    expectCar(1'b0, 1, cyc + 2, GC, 1'b1);
    entry_req = 1'b1;
    repeat (10) @(negedge clk);
    waitQueue(0, 5, "single_entry");
    entry_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("single_entry_count", count, 1);

    for (int c = 2; c <= 6; c++) serveCar(1'b0, c);
    checkOutput("filled_full", full, 1);
    serveCar(1'b1, 5);

    // Tie at count 5 after an exit: entry first, then the held exit.
    expectCar(1'b0, 6, -1, GC, 1'b1);
    expectCar(1'b1, 5, -1, GC, 1'b1);
    applyStimulus(1'b1, 1'b1);
    waitQueue(1, 30, "tie_entry");
    entry_req = 1'b0;
    waitQueue(0, 30, "tie_exit");
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("tie_count", count, 5);

    serveCar(1'b0, 6);
    checkOutput("cap_full", full, 1);
    holdNoGrant(1'b1, 1'b0, 12);
    checkOutput("cap_count_held", count, 6);
    checkOutput("cap_full_held", full, 1);
    serveCar(1'b1, 5);
    checkOutput("cap_exit_full", full, 0);

    for (int c = 4; c >= 0; c--) serveCar(1'b1, c);
    checkOutput("drained_empty", empty, 1);
    holdNoGrant(1'b0, 1'b1, 12);
    checkOutput("empty_exit_count", count, 0);
    checkOutput("empty_exit_err", err, 0);
    checkOutput("empty_exit_empty", empty, 1);

    // Reset asserted during the second gate cycle, between clock edges.
    expectCar(1'b0, 1, -1, 2, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midgate_gate_in", gate_in_open, 0);
    checkOutput("midgate_count", count, 0);
    checkOutput("midgate_empty", empty, 1);
    entry_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    waitQueue(0, 5, "midgate");
    serveCar(1'b0, 1);
    checkOutput("post_reset_count", count, 1);
    checkOutput("final_err", err, 0);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
